// File: rtl/axi_slave_mem.sv
// AXI slave backed by a 16-word memory. It handles one transaction at a time.
// Supported bursts are INCR (index wraps mod 16) and FIXED. A WRAP or reserved
// burst, or an address above the 16-word window, is answered with SLVERR and
// never touches memory.
// Ports: s_axi_aclk / s_axi_aresetn (async, active-low), plus the AXI channels:
//   AW (valid/ready/addr/id/len/burst), W (valid/ready/data/strb/last),
//   B (valid/ready/resp/id), AR (valid/ready/addr/id/len/burst),
//   R (valid/ready/data/resp/id/last).
module axi_slave_mem #(
  parameter int data_width = 32
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_awaddr,
  input  logic [3:0]              s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [data_width-1:0]   s_axi_wdata,
  input  logic [data_width/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  output logic [3:0]              s_axi_bid,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [31:0]             s_axi_araddr,
  input  logic [3:0]              s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [data_width-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic [3:0]              s_axi_rid,
  output logic                    s_axi_rlast
);
  localparam int SW = data_width / 8;
  localparam int OB = $clog2(SW);   // byte-offset bits below the word index

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

  state_e                  state_q, state_d;
  logic                    rdy_q, rdy_d;        // address-channel ready, IDLE only
  logic                    wr_turn_q, wr_turn_d; // write wins the next tie
  logic [3:0]              idx_q, idx_d;
  logic [3:0]              id_q, id_d;
  logic [7:0]              len_q, len_d;
  logic [1:0]              burst_q, burst_d;
  logic                    err_q, err_d;        // range or burst error
  logic [8:0]              cnt_q, cnt_d;        // beats already transferred
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [data_width-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    rlast_q, rlast_d;

  logic [data_width-1:0]   mem [16];

  logic       aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic [3:0] aw_idx, ar_idx, idx_nxt;
  logic       aw_err, ar_err;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^{s_axi_awaddr[OB-1:0], s_axi_araddr[OB-1:0]};

  assign aw_idx  = s_axi_awaddr[OB+3:OB];
  assign ar_idx  = s_axi_araddr[OB+3:OB];
  assign aw_err  = (|s_axi_awaddr[31:OB+4]) | s_axi_awburst[1];
  assign ar_err  = (|s_axi_araddr[31:OB+4]) | s_axi_arburst[1];
  assign idx_nxt = (burst_q == 2'b01) ? idx_q + 4'd1 : idx_q;

  // The readies come from a register. When both valids are high, the side that
  // does not hold the turn is masked, so a tie can never complete two handshakes.
  assign s_axi_awready = rdy_q & ~(s_axi_arvalid & ~wr_turn_q);
  assign s_axi_arready = rdy_q & ~(s_axi_awvalid &  wr_turn_q);
  assign s_axi_wready  = (state_q == WR_DATA);
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = id_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = id_q;
  assign s_axi_rlast   = rlast_q;

  assign aw_hs = (state_q == IDLE) & s_axi_awvalid & s_axi_awready;
  assign ar_hs = (state_q == IDLE) & s_axi_arvalid & s_axi_arready;
  assign w_hs  = (state_q == WR_DATA) & s_axi_wvalid;
  assign b_hs  = (state_q == WR_RESP) & bvalid_q & s_axi_bready;
  assign r_hs  = (state_q == RD_DATA) & rvalid_q & s_axi_rready;

  always_comb begin
    state_d   = state_q;
    wr_turn_d = wr_turn_q;
    idx_d     = idx_q;
    id_d      = id_q;
    len_d     = len_q;
    burst_d   = burst_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          idx_d     = aw_idx;
          id_d      = s_axi_awid;
          len_d     = s_axi_awlen;
          burst_d   = s_axi_awburst;
          err_d     = aw_err;
          cnt_d     = '0;
          wr_turn_d = 1'b0;
          state_d   = WR_DATA;
        end else if (ar_hs) begin
          idx_d     = ar_idx;
          id_d      = s_axi_arid;
          len_d     = s_axi_arlen;
          burst_d   = s_axi_arburst;
          err_d     = ar_err;
          cnt_d     = '0;
          wr_turn_d = 1'b1;
          rvalid_d  = 1'b1;
          rdata_d   = ar_err ? '0 : mem[ar_idx];
          rresp_d   = ar_err ? 2'b10 : 2'b00;
          rlast_d   = (s_axi_arlen == 8'd0);
          state_d   = RD_DATA;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          idx_d = idx_nxt;
          // Saturate so that a runaway burst cannot wrap back to a matching count.
          cnt_d = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
          if (s_axi_wlast) begin
            bvalid_d = 1'b1;
            bresp_d  = (err_q || cnt_q != {1'b0, len_q}) ? 2'b10 : 2'b00;
            state_d  = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            idx_d   = idx_nxt;
            cnt_d   = cnt_q + 9'd1;
            rdata_d = err_q ? '0 : mem[idx_nxt];
            rlast_d = (cnt_q[7:0] + 8'd1 == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy_d = (state_d == IDLE);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      wr_turn_q <= 1'b1;
      idx_q     <= '0;
      id_q      <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      wr_turn_q <= wr_turn_d;
      idx_q     <= idx_d;
      id_q      <= id_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge s_axi_aclk) begin
    if (w_hs && !err_q) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi_wstrb[b]) mem[idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;
  logic        clk, rst_n;
  logic        awvalid, awready; logic [31:0] awaddr; logic [3:0] awid;
  logic [7:0]  awlen; logic [1:0] awburst;
  logic        wvalid, wready, wlast; logic [31:0] wdata; logic [3:0] wstrb;
  logic        bvalid, bready; logic [1:0] bresp; logic [3:0] bid;
  logic        arvalid, arready; logic [31:0] araddr; logic [3:0] arid;
  logic [7:0]  arlen; logic [1:0] arburst;
  logic        rvalid, rready, rlast; logic [31:0] rdata; logic [1:0] rresp;
  logic [3:0]  rid;

  int total = 0;
  int bad   = 0;

  axi_slave_mem #(.data_width(32)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_bid(bid),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rid(rid), .s_axi_rlast(rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] bt);
    int n = 0;
    awaddr = a; awid = id; awlen = len; awburst = bt; awvalid = 1'b1; #1;
    while (!awready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("aw_timeout", 0, 1);
    tick(); awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1; #1;
    while (!wready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("w_timeout", 0, 1);
    tick(); wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_get(input string tag, input logic [1:0] er, input logic [3:0] eid);
    int n = 0;
    bready = 1'b1; #1;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (n >= 20) chk({tag, "_b_timeout"}, 0, 1);
    chk({tag, "_bresp"}, bresp, er);
    chk({tag, "_bid"}, bid, eid);
    tick(); bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] bt);
    int n = 0;
    araddr = a; arid = id; arlen = len; arburst = bt; arvalid = 1'b1; #1;
    while (!arready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("ar_timeout", 0, 1);
    tick(); arvalid = 1'b0;
    chk("rvalid_after_ar", rvalid, 1'b1);
  endtask

  task automatic r_get(input string tag, input logic [31:0] ed, input logic [1:0] er,
                       input logic el, input logic [3:0] eid);
    int n = 0;
    rready = 1'b1; #1;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (n >= 20) chk({tag, "_r_timeout"}, 0, 1);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rresp"}, rresp, er);
    chk({tag, "_rlast"}, rlast, el);
    chk({tag, "_rid"}, rid, eid);
    tick(); rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 0;

    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    #2 rst_n = 1'b1; #1;
    chk("rel_awready_pre", awready, 0);
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);

    // INCR write of 1..4 at word 2, then read back
    aw_send(32'h8, 4'h5, 8'd3, 2'b01);
    w_beat(32'd1, 4'hF, 0); w_beat(32'd2, 4'hF, 0);
    w_beat(32'd3, 4'hF, 0); w_beat(32'd4, 4'hF, 1);
    b_get("incr_w", 2'b00, 4'h5);
    ar_send(32'h8, 4'h9, 8'd3, 2'b01);
    r_get("incr_r0", 32'd1, 2'b00, 0, 4'h9);
    r_get("incr_r1", 32'd2, 2'b00, 0, 4'h9);
    r_get("incr_r2", 32'd3, 2'b00, 0, 4'h9);
    r_get("incr_r3", 32'd4, 2'b00, 1, 4'h9);

    // INCR from word 15 wraps to word 0
    aw_send(32'h3C, 4'h1, 8'd1, 2'b01);
    w_beat(32'hA0, 4'hF, 0); w_beat(32'hA1, 4'hF, 1);
    b_get("wrap15_w", 2'b00, 4'h1);
    ar_send(32'h3C, 4'h2, 8'd1, 2'b01);
    r_get("wrap15_r0", 32'hA0, 2'b00, 0, 4'h2);
    r_get("wrap15_r1", 32'hA1, 2'b00, 1, 4'h2);
    ar_send(32'h0, 4'h2, 8'd0, 2'b00);
    r_get("word0_fixed", 32'hA1, 2'b00, 1, 4'h2);

    // byte strobe merge
    aw_send(32'h10, 4'h3, 8'd0, 2'b01);
    w_beat(32'h12345678, 4'hF, 1);
    b_get("strb_w0", 2'b00, 4'h3);
    aw_send(32'h10, 4'h3, 8'd0, 2'b01);
    w_beat(32'hFFFFFFFF, 4'h1, 1);
    b_get("strb_w1", 2'b00, 4'h3);
    ar_send(32'h10, 4'h3, 8'd0, 2'b01);
    r_get("strb_r", 32'h123456FF, 2'b00, 1, 4'h3);

    // error cases
    aw_send(32'h20, 4'h7, 8'd3, 2'b01);
    w_beat(32'h11, 4'hF, 0); w_beat(32'h22, 4'hF, 1);
    b_get("short_w", 2'b10, 4'h7);
    aw_send(32'h20, 4'h8, 8'd1, 2'b10);
    w_beat(32'hDEAD, 4'hF, 0); w_beat(32'hBEEF, 4'hF, 1);
    b_get("wrapburst_w", 2'b10, 4'h8);
    aw_send(32'h40, 4'h1, 8'd0, 2'b01);
    w_beat(32'hBAD, 4'hF, 1);
    b_get("oor_w", 2'b10, 4'h1);
    ar_send(32'h20, 4'h4, 8'd0, 2'b01);
    r_get("nowrite_wrap", 32'h11, 2'b00, 1, 4'h4);
    ar_send(32'h0, 4'h4, 8'd0, 2'b01);
    r_get("nowrite_oor", 32'hA1, 2'b00, 1, 4'h4);
    ar_send(32'h20, 4'h6, 8'd1, 2'b10);
    r_get("wrapburst_r0", 32'h0, 2'b10, 0, 4'h6);
    r_get("wrapburst_r1", 32'h0, 2'b10, 1, 4'h6);
    ar_send(32'h100, 4'hA, 8'd0, 2'b01);
    r_get("oor_r", 32'h0, 2'b10, 1, 4'hA);

    // arbitration: the last grant was a read, so write wins the first tie
    awaddr = 32'h0; awid = 4'h2; awlen = 0; awburst = 2'b01; awvalid = 1'b1;
    araddr = 32'h8; arid = 4'h3; arlen = 0; arburst = 2'b01; arvalid = 1'b1;
    #1;
    chk("arb1_awready", awready, 1);
    chk("arb1_arready", arready, 0);
    tick(); awvalid = 1'b0; #1;
    chk("arb1_arready_busy", arready, 0);
    w_beat(32'h55, 4'hF, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bstall_bvalid", bvalid, 1);
      chk("bstall_bresp", bresp, 2'b00);
      chk("bstall_bid", bid, 4'h2);
      tick();
    end
    awaddr = 32'hC; awid = 4'h4; awlen = 0; awvalid = 1'b1; bready = 1'b1;
    tick(); bready = 1'b0; #1;
    chk("arb2_arready", arready, 1);
    chk("arb2_awready", awready, 0);
    tick(); arvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rstall_rvalid", rvalid, 1);
      chk("rstall_rdata", rdata, 32'd1);
      chk("rstall_rlast", rlast, 1);
      chk("rstall_rid", rid, 4'h3);
      tick();
    end
    araddr = 32'h8; arid = 4'h6; arvalid = 1'b1; rready = 1'b1;
    tick(); rready = 1'b0; #1;
    chk("arb3_awready", awready, 1);
    chk("arb3_arready", arready, 0);
    tick(); awvalid = 1'b0;
    w_beat(32'h77, 4'hF, 1);
    b_get("arb3_w", 2'b00, 4'h4);
    #1;
    chk("arb4_arready", arready, 1);
    tick(); arvalid = 1'b0;
    r_get("arb4_r", 32'd1, 2'b00, 1, 4'h6);

    // reset in the middle of a read burst
    ar_send(32'h8, 4'hB, 8'd3, 2'b01);
    r_get("mid_r0", 32'd1, 2'b00, 0, 4'hB);
    rst_n = 1'b0; #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_rid", rid, 0);
    chk("midrst_arready", arready, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("midrel_awready", awready, 1);
    chk("midrel_arready", arready, 1);
    ar_send(32'hC, 4'h1, 8'd0, 2'b01);
    r_get("mem_kept", 32'h77, 2'b00, 1, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
